// File: rtl/jk_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_pkg
// Purpose  : Shared types and helpers for the JK bank arbiter slice:
//            JK command encoding, arbiter FSM state encoding and the JK
//            next-state function.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package jk_bank_pkg;

    // {J,K} command encoding as seen on req_cmd
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        CLR  = 2'b01,
        SET  = 2'b10,
        TGL  = 2'b11
    } jk_cmd_e;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } jk_arb_state_e;

    // Value of a JK cell after applying {J,K} to current value q
    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        logic r;
        case (jk)
            HOLD:    r = q;
            CLR:     r = 1'b0;
            SET:     r = 1'b1;
            default: r = ~q;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_cell_en.sv
`default_nettype none
// ============================================================================
// Module   : jk_cell_en
// Purpose  : Single JK storage bit with synchronous reset and update enable.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset (clears q)
//            en   - apply {j,k} on this rising edge
//            j, k - JK command inputs
//            q    - registered cell value
// Revision : 1.0  initial release
// ============================================================================
module jk_cell_en
    import jk_bank_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (en) begin
            r_q <= jk_next(r_q, {j, k});
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_arbiter
// Purpose  : Arbitrates NREQ requesters issuing single-bit JK commands to a
//            bank of NBITS JK cells, applies one command at a time and
//            returns the post-update bit value to the winner.
//            Build option JK_BANK_ARB_RR_EN: when defined, round-robin
//            arbitration with a rotating pointer; when undefined, fixed
//            priority (lowest requester index wins) with no pointer.
// Ports    : clk, rst    - clock, synchronous active-high reset
//            req_valid   - per-requester command valid        [NREQ]
//            req_ready   - per-requester accept, one-hot/zero [NREQ]
//            req_cmd     - {J,K} per requester                [2*NREQ]
//            req_idx     - target bit per requester           [NREQ*IDXW]
//            resp_valid  - response available
//            resp_ready  - response consumer accept
//            resp_id     - requester owning the response      [IDW]
//            resp_q      - target bit value after the update
//            resp_err    - index out of range, command dropped
//            q_bank      - live bank contents                 [NBITS]
//            busy        - FSM not idle
// Revision : 1.0  initial release
// ============================================================================
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = (NBITS > 1) ? $clog2(NBITS) : 1,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [2*NREQ-1:0]      req_cmd,
    input  logic [NREQ*IDXW-1:0]   req_idx,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic                   resp_q,
    output logic                   resp_err,
    output logic [NBITS-1:0]       q_bank,
    output logic                   busy
);

    localparam logic [1:0] c_idle = ST_IDLE;
    localparam logic [1:0] c_exec = ST_EXEC;
    localparam logic [1:0] c_resp = ST_RESP;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    // Latched command of the current owner
    logic [IDW-1:0]   r_id;
    logic [1:0]       r_cmd;
    logic [IDXW-1:0]  r_idx;

    logic [IDW-1:0]   w_win;
    logic             w_any;
    logic             w_grant;

    logic [NBITS-1:0] w_bank;
    logic [NBITS-1:0] w_cell_en;
    logic             w_in_range;
    logic             w_cur;

    logic             r_resp_valid;
    logic [IDW-1:0]   r_resp_id;
    logic             r_resp_q;
    logic             r_resp_err;
    logic             r_busy;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef JK_BANK_ARB_RR_EN
    logic [IDW-1:0] r_ptr;
    logic [IDW:0]   w_cand;

    // Ascending search starting at r_ptr with wrap; one extra bit keeps the
    // sum from overflowing before the modulo correction.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = {1'b0, r_ptr} + (IDW+1)'(i);
            if (w_cand >= (IDW+1)'(NREQ)) begin
                w_cand = w_cand - (IDW+1)'(NREQ);
            end
            if (!w_any && req_valid[w_cand[IDW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_cand[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_win == IDW'(NREQ-1)) ? '0 : w_win + IDW'(1);
        end
    end
`else
    // Descending scan so the lowest asserted index is the last written
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_any = 1'b1;
                w_win = IDW'(i);
            end
        end
    end
`endif

    // req_ready is combinational; suppressed during reset so every output
    // reads 0 while rst is asserted.
    assign w_grant   = (r_state == c_idle) && w_any && !rst;
    assign req_ready = w_grant ? (NREQ'(1) << w_win) : '0;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_any) w_state_nxt = c_exec;
            c_exec:  w_state_nxt = c_resp;
            c_resp:  if (resp_ready) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    assign w_in_range = ({1'b0, r_idx} < (IDXW+1)'(NBITS));
    assign w_cur      = w_in_range ? w_bank[r_idx] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_idle;
            r_busy       <= 1'b0;
            r_id         <= '0;
            r_cmd        <= '0;
            r_idx        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_q     <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_idle);

            if (w_grant) begin
                r_id  <= w_win;
                r_cmd <= req_cmd[2*w_win +: 2];
                r_idx <= req_idx[w_win*IDXW +: IDXW];
            end

            // The response value is computed from the pre-update cell so it
            // matches the bank content the cell takes on this same edge.
            if (r_state == c_exec) begin
                r_resp_valid <= 1'b1;
                r_resp_id    <= r_id;
                r_resp_err   <= !w_in_range;
                r_resp_q     <= w_in_range ? jk_next(w_cur, r_cmd) : 1'b0;
            end else if ((r_state == c_resp) && resp_ready) begin
                r_resp_valid <= 1'b0;
                r_resp_id    <= '0;
                r_resp_err   <= 1'b0;
                r_resp_q     <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Cell bank: only the addressed cell is enabled, and only in EXEC
    // ------------------------------------------------------------------
    generate
        for (genvar b = 0; b < NBITS; b++) begin : g_cells
            assign w_cell_en[b] = (r_state == c_exec) && w_in_range &&
                                  (r_idx == IDXW'(b));
            jk_cell_en u_cell (
                .clk (clk),
                .rst (rst),
                .en  (w_cell_en[b]),
                .j   (r_cmd[1]),
                .k   (r_cmd[0]),
                .q   (w_bank[b])
            );
        end
    endgenerate

    assign q_bank     = w_bank;
    assign busy       = r_busy;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_q     = r_resp_q;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire
